// File: rtl/nios2_mult_pkg.sv
// Shared definitions for the Nios II pipelined multiplier: op encodings and
// partial-product sizing.
package nios2_mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  function automatic int unsigned pp_count(input int unsigned data_w);
    return (data_w / 16) * (data_w / 16);
  endfunction

endpackage

// File: rtl/nios2_mult_pp16.sv
// Registered 16x16 unsigned multiplier cell; holds when en_i is low.
module nios2_mult_pp16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     p_o <= '0;
    else if (en_i) p_o <= a_i * b_i;
  end

endmodule

// File: rtl/nios2_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier: 16x16 partial products in stage 1,
// summation plus signed high-word correction in stage 2, then delay stages.
module nios2_mult_pipe
  import nios2_mult_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [1:0]        op,
  input  logic [TAG_W-1:0]  tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int NCH = DATA_W / 16;
  localparam int NPP = pp_count(DATA_W);

  logic                     en, accept;
  logic [PIPE_STAGES:1]     vld_pipe_q;
  logic [NPP-1:0][31:0]     pp;
  logic [1:0]               op_q;
  logic [TAG_W-1:0]         tag1_q, tag2_q;
  logic [DATA_W-1:0]        a_q, b_q, res2_q;
  logic [2*DATA_W-1:0]      prod_d, term;
  logic [DATA_W-1:0]        hi_d, res_d;

  assign en        = ~(out_valid & ~out_ready);
  assign in_ready  = en & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_pipe_q[PIPE_STAGES];
  assign busy      = |vld_pipe_q;

  for (genvar i = 0; i < NCH; i++) begin : g_a
    for (genvar j = 0; j < NCH; j++) begin : g_b
      nios2_mult_pp16 u_pp (
        .clk  (clk),
        .reset(reset),
        .en_i (en),
        .a_i  (src1[16*i +: 16]),
        .b_i  (src2[16*j +: 16]),
        .p_o  (pp[i*NCH + j])
      );
    end
  end

  // Flush wins over a stall: valid bits drop even when the pipe is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      vld_pipe_q <= '0;
    else if (flush) vld_pipe_q <= '0;
    else if (en)    vld_pipe_q <= {vld_pipe_q[PIPE_STAGES-1:1], accept};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_MUL;
      tag1_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (en) begin
      op_q   <= op;
      tag1_q <= tag;
      a_q    <= src1;
      b_q    <= src2;
    end
  end

  // Unsigned product, then fold in the two's-complement weight of each MSB.
  always_comb begin
    prod_d = '0;
    term   = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < NCH; j++) begin
        term        = '0;
        term[31:0]  = pp[i*NCH + j];
        prod_d      = prod_d + (term << (16 * (i + j)));
      end
    end
    hi_d = prod_d[2*DATA_W-1:DATA_W];
    if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[DATA_W-1]) hi_d = hi_d - b_q;
    if (op_q == OP_MULXSS && b_q[DATA_W-1])                        hi_d = hi_d - a_q;
    res_d = (op_q == OP_MUL) ? prod_d[DATA_W-1:0] : hi_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res2_q <= '0;
      tag2_q <= '0;
    end else if (en) begin
      res2_q <= res_d;
      tag2_q <= tag1_q;
    end
  end

  if (PIPE_STAGES > 2) begin : g_dly
    logic [PIPE_STAGES-3:0][DATA_W-1:0] res_dly_q;
    logic [PIPE_STAGES-3:0][TAG_W-1:0]  tag_dly_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        res_dly_q <= '0;
        tag_dly_q <= '0;
      end else if (en) begin
        res_dly_q[0] <= res2_q;
        tag_dly_q[0] <= tag2_q;
        for (int s = 1; s < PIPE_STAGES - 2; s++) begin
          res_dly_q[s] <= res_dly_q[s-1];
          tag_dly_q[s] <= tag_dly_q[s-1];
        end
      end
    end

    assign result  = res_dly_q[PIPE_STAGES-3];
    assign out_tag = tag_dly_q[PIPE_STAGES-3];
  end else begin : g_nodly
    assign result  = res2_q;
    assign out_tag = tag2_q;
  end

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Bench: directed table and corner sequences on a 32-bit/2-stage instance,
// randomized traffic on a 64-bit/4-stage instance against a 128-bit model.
module tb_nios2_mult_pipe;
  import nios2_mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 2-stage instance
  logic        rst_a, iv_a, ir_a, fl_a, ov_a, or_a, busy_a;
  logic [31:0] s1_a, s2_a, res_a;
  logic [1:0]  op_a;
  logic [4:0]  tag_a, otag_a;

  // 64-bit, 4-stage instance
  logic        rst_b, iv_b, ir_b, fl_b, ov_b, or_b, busy_b;
  logic [63:0] s1_b, s2_b, res_b;
  logic [1:0]  op_b;
  logic [4:0]  tag_b, otag_b;

  nios2_mult_pipe #(.DATA_W(32), .PIPE_STAGES(2), .TAG_W(5)) dut32 (
    .clk(clk), .reset(rst_a), .in_valid(iv_a), .in_ready(ir_a), .src1(s1_a), .src2(s2_a),
    .op(op_a), .tag(tag_a), .flush(fl_a), .out_valid(ov_a), .out_ready(or_a),
    .result(res_a), .out_tag(otag_a), .busy(busy_a));

  nios2_mult_pipe #(.DATA_W(64), .PIPE_STAGES(4), .TAG_W(5)) dut64 (
    .clk(clk), .reset(rst_b), .in_valid(iv_b), .in_ready(ir_b), .src1(s1_b), .src2(s2_b),
    .op(op_b), .tag(tag_b), .flush(fl_b), .out_valid(ov_b), .out_ready(or_b),
    .result(res_b), .out_tag(otag_b), .busy(busy_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: extend each operand to 128 bits per its signedness, multiply.
  function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] o);
    logic [127:0] xa, xb, p;
    xa = (o == OP_MULXSU || o == OP_MULXSS) ? {{64{a[63]}}, a} : {64'd0, a};
    xb = (o == OP_MULXSS) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = xa * xb;
    return (o == OP_MUL) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'd1;
      4:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] r;
    logic [4:0]  t;
    int          cyc;
  } exp64_t;

  vec_t tbl[10];

  task automatic run64(input int n, input bit bp);
    exp64_t q[$];
    exp64_t e;
    int sent = 0, cyc = 0;
    while ((sent < n || q.size() > 0) && cyc < 40000) begin
      @(negedge clk);
      iv_b  = (sent < n) && ($urandom_range(3) != 0);
      s1_b  = pick();
      s2_b  = pick();
      op_b  = 2'($urandom_range(3));
      tag_b = 5'($urandom);
      or_b  = bp ? ($urandom_range(2) != 0) : 1'b1;
      #1;
      if (ov_b && or_b) begin
        if (q.size() == 0) chk("r64_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("r64_result", res_b, e.r);
          chk("r64_tag", otag_b, e.t);
          if (!bp) chk("r64_latency", cyc - e.cyc, 4);
        end
      end
      if (iv_b && ir_b) begin
        q.push_back('{ref64(s1_b, s2_b, op_b), tag_b, cyc});
        sent++;
      end
      cyc++;
    end
    chk("r64_drain", q.size() + (sent < n ? 1 : 0), 0);
    iv_b = 1'b0;
  endtask

  initial begin
    logic [31:0] sa[3], sb[3], se[3];
    int sent, got, stall;
    bit seen;

    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL,    5'd1,  32'h0000_0001};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULXUU, 5'd2,  32'hFFFF_FFFE};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULXSU, 5'd3,  32'hFFFF_FFFF};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULXSS, 5'd4,  32'h0000_0000};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, OP_MULXSS, 5'd5,  32'h4000_0000};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, OP_MULXUU, 5'd6,  32'h4000_0000};
    tbl[6] = '{32'h8000_0000, 32'h8000_0000, OP_MUL,    5'd7,  32'h0000_0000};
    tbl[7] = '{32'hFFFF_FFFE, 32'h0000_0003, OP_MULXSU, 5'd8,  32'hFFFF_FFFF};
    tbl[8] = '{32'hFFFF_FFFE, 32'h0000_0003, OP_MULXUU, 5'd9,  32'h0000_0002};
    tbl[9] = '{32'hFFFF_FFFE, 32'h0000_0003, OP_MUL,    5'd10, 32'hFFFF_FFFA};

    {iv_a, fl_a, s1_a, s2_a, op_a, tag_a} = '0;
    {iv_b, fl_b, s1_b, s2_b, op_b, tag_b} = '0;
    or_a = 1'b1; or_b = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    chk("rst_out_valid", ov_a, 0);
    chk("rst_busy", busy_a, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_in_ready", ir_a, 1);
    chk("rst_result", res_a, 0);
    chk("rst_out_tag", otag_a, 0);
    chk("rst_out_valid_post", ov_a, 0);

    // Table: one isolated accept per vector, result exactly 2 cycles later
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv_a = 1'b1; s1_a = tbl[i].a; s2_a = tbl[i].b; op_a = tbl[i].op; tag_a = tbl[i].tag;
      #1 chk("tbl_in_ready", ir_a, 1);
      @(negedge clk);
      iv_a = 1'b0;
      #1 chk("tbl_early_valid", ov_a, 0);
      @(negedge clk);
      #1;
      chk("tbl_valid", ov_a, 1);
      chk("tbl_result", res_a, tbl[i].exp);
      chk("tbl_tag", otag_a, tbl[i].tag);
    end

    // Back-to-back stream with a 3-cycle stall after the first result
    sa = '{32'd7, 32'd3, 32'h1_0000};
    sb = '{32'd6, 32'd5, 32'h1_0000};
    se = '{32'd42, 32'd15, 32'd0};
    sent = 0; got = 0; stall = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov_a && stall < 0) stall = 3;
      or_a  = !(stall > 0);
      iv_a  = sent < 3;
      s1_a  = (sent < 3) ? sa[sent] : 32'd0;
      s2_a  = (sent < 3) ? sb[sent] : 32'd0;
      op_a  = OP_MUL;
      tag_a = 5'(sent + 1);
      #1;
      if (ov_a && !or_a) begin
        chk("stall_result", res_a, se[got]);
        chk("stall_tag", otag_a, got + 1);
        chk("stall_in_ready", ir_a, 0);
      end
      if (ov_a && or_a) begin
        if (got < 3) begin
          chk("stream_result", res_a, se[got]);
          chk("stream_tag", otag_a, got + 1);
        end else chk("stream_duplicate", got, 2);
        got++;
      end
      if (iv_a && ir_a) sent++;
      if (stall > 0) stall--;
    end
    chk("stream_count", got, 3);
    iv_a = 1'b0; or_a = 1'b1;

    // Flush with two operations in flight
    @(negedge clk);
    iv_a = 1'b1; s1_a = 32'd2; s2_a = 32'd3; op_a = OP_MUL; tag_a = 5'd11;
    @(negedge clk);
    s1_a = 32'd4; s2_a = 32'd5; tag_a = 5'd12;
    @(negedge clk);
    fl_a = 1'b1; s1_a = 32'd9; tag_a = 5'd14;
    #1 chk("flush_in_ready", ir_a, 0);
    @(negedge clk);
    fl_a = 1'b0; iv_a = 1'b0;
    #1;
    chk("flush_busy", busy_a, 0);
    chk("flush_out_valid", ov_a, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1 if (ov_a) seen = 1'b1;
    end
    chk("flush_no_emit", seen, 0);
    @(negedge clk);
    iv_a = 1'b1; s1_a = 32'd9; s2_a = 32'd9; op_a = OP_MUL; tag_a = 5'd13;
    @(negedge clk);
    iv_a = 1'b0;
    @(negedge clk);
    #1;
    chk("post_flush_valid", ov_a, 1);
    chk("post_flush_result", res_a, 81);
    chk("post_flush_tag", otag_a, 13);

    // Asynchronous reset between edges with the pipe full
    @(negedge clk);
    or_a = 1'b0; iv_a = 1'b1; s1_a = 32'd7; s2_a = 32'd7; tag_a = 5'd20;
    @(negedge clk);
    s1_a = 32'd8; s2_a = 32'd8; tag_a = 5'd21;
    @(negedge clk);
    iv_a = 1'b0;
    #1;
    chk("prerst_out_valid", ov_a, 1);
    #1 rst_a = 1'b1;
    #1;
    chk("arst_out_valid", ov_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_result", res_a, 0);
    chk("arst_tag", otag_a, 0);
    @(negedge clk);
    rst_a = 1'b0; or_a = 1'b1;
    #1 chk("arst_in_ready", ir_a, 1);

    // 64-bit, 4-stage randomized traffic
    run64(10000, 1'b0);
    run64(2000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios2_mult_pipe.md
Name: nios2_mult_pipe

Overview:
Parametrised pipelined integer multiplier for the Nios II execute/memory path. It is the successor to the three-partial-product low-word cell. It adds:
- the full double-width product, with result selection for MUL / MULXUU / MULXSU / MULXSS;
- generic operand width;
- configurable latency;
- a valid/ready handshake with backpressure, flush, and a tag that travels with each operation.

The block sits between the E-stage operand muxes and the M/W writeback merge.

Parameters:
- DATA_W, 32, operand and result width. Must be a multiple of 16, range 16..64.
- PIPE_STAGES, 2, accept-to-output latency in cycles. Range 2..4.
- TAG_W, 5, width of the sideband tag (destination register index).

Ports:
- clk  in  1  system clock; all state is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept this cycle.
- src1  in  DATA_W  operand A.
- src2  in  DATA_W  operand B.
- op  in  2  00 MUL (low word), 01 MULXUU (high, u×u), 10 MULXSU (high, A signed × B unsigned), 11 MULXSS (high, s×s).
- tag  in  TAG_W  sideband, returned unchanged with the result.
- flush  in  1  discard all in-flight operations.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  DATA_W  selected product word.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (async, active-high):
  - All stage valid bits, result and out_tag clear to 0.
  - out_valid = 0, busy = 0, in_ready = 1 after reset deasserts.
- Accept and advance:
  - Accept occurs when in_valid & in_ready.
  - Global advance: en = ~(out_valid & ~out_ready).
  - in_ready = en & ~flush.
  - With en = 0 every stage register holds, data and valid alike.
  - Pipeline bubbles are not collapsed.
- Stage 1 (register):
  - (DATA_W/16)² unsigned 16×16 partial products of src1 and src2.
  - Also registered: op, tag, src1, src2 (needed for the sign correction), and valid.
- Stage 2:
  - Sum partial products with shifts of 16·(i+j) into an unsigned 2·DATA_W product P.
  - Signed correction on the upper half:
    - subtract src2 if A is signed (op 10/11) and src1[MSB] = 1;
    - subtract src1 if B is signed (op 11) and src2[MSB] = 1;
    - arithmetic is modulo 2^DATA_W.
  - Select: op 00 → P[DATA_W-1:0]; otherwise the corrected P[2·DATA_W-1:DATA_W].
  - The low word never depends on signedness.
  - Register result, out_tag, valid.
- Stages 3..PIPE_STAGES are pure delay registers (retiming slack). out_valid is the last stage valid bit.
- Latency: with out_ready held high, a result appears exactly PIPE_STAGES cycles after accept. Throughput is one operation per cycle.
- Backpressure: while out_valid & ~out_ready, result and out_tag stay stable and in_ready = 0.
- Flush:
  - On the next edge all valid bits clear, including out_valid; data registers may keep stale values.
  - An input presented in the same cycle is not accepted (in_ready = 0).
  - Flush overrides backpressure.
- Simultaneous flush and out_ready: the output handshake does not complete; the result is discarded.
- Reset asserted mid-operation: in-flight operations are lost; no partial output.
- The data path never uses X-propagating defaults; unused op encodings do not exist.

Decomposition:
- Shared package nios2_mult_pkg: op encoding constants (OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS) and a function computing the partial-product count from DATA_W.
- One sub-module, nios2_mult_pp16: registered 16×16 unsigned multiplier with enable and async clear, instantiated (DATA_W/16)² times via generate.
- Correction, summation and the delay chain stay in the top level.

Test Plan:
- DATA_W=32, src1=src2=0xFFFFFFFF, one accept per op, out_ready=1:
  - MUL → 0x00000001;
  - MULXUU → 0xFFFFFFFE;
  - MULXSU → 0xFFFFFFFF;
  - MULXSS → 0x00000000;
  - each exactly 2 cycles after accept, with tags echoed.
- src1=src2=0x80000000: MULXSS → 0x40000000, MULXUU → 0x40000000, MUL → 0x00000000.
- Back-to-back stream 7×6, 3×5, 0x10000×0x10000 (MUL), with out_ready low for 3 cycles after the first result:
  - outputs 42, 15, 0 in order;
  - result and out_tag are stable during the stall;
  - in_ready = 0 during the stall;
  - no drops or duplicates.
- Two operations in flight, flush pulsed one cycle: next cycle busy = 0 and out_valid = 0, and no result is ever emitted for them. A new operation accepted after the flush returns correctly.
- Reset asserted asynchronously mid-cycle with the pipe full: outputs are 0 immediately, without waiting for a clock edge; in_ready = 1 after release.
- PIPE_STAGES=4, DATA_W=64, random signed/unsigned operands checked against a 128-bit reference model: latency 4, all four ops bit-exact over 10k vectors.
